// File: rtl/snake_plot_scheduler.sv
// Shares the vga_adapter pixel port between NREQ block requesters, rastering each grant as an XDIM x YDIM block.
// Latency: LOAD one cycle after req, first plot the cycle after that, ack XDIM*YDIM+2 cycles after req.
// Backpressure: none toward the adapter; requesters hold req until ack, and requests arriving mid-block wait for IDLE.
module snake_plot_scheduler #(
    parameter int NREQ    = 3,
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int XDIM    = 10,
    parameter int YDIM    = 10,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120
) (
    input  logic                 CLOCK_50,
    input  logic                 Resetn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*XW-1:0]   req_x,
    input  logic [NREQ*YW-1:0]   req_y,
    input  logic [NREQ*3-1:0]    req_colour,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic                 plot,
    output logic [XW-1:0]        vga_x,
    output logic [YW-1:0]        vga_y,
    output logic [2:0]           vga_colour
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   winner;
    logic [XW-1:0]   bx;
    logic [YW-1:0]   by;
    logic [2:0]      col;
    logic [XW-1:0]   xc;
    logic [YW-1:0]   yc;

    logic [XW-1:0]   sel_x;
    logic [YW-1:0]   sel_y;
    logic [2:0]      sel_colour;
    logic [NREQ-1:0] ack_onehot;

    logic            last_col;
    logic            last_row;
    logic [XW-1:0]   xc_nxt;
    logic [YW-1:0]   yc_nxt;
    logic [XW-1:0]   base_x;
    logic [YW-1:0]   base_y;
    logic [XW-1:0]   ox;
    logic [YW-1:0]   oy;
    logic [XW:0]     sum_x;
    logic [YW:0]     sum_y;
    logic            pix_ok;

    // Lowest set index wins; scanning downward leaves the lowest one in place.
    always_comb begin
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) winner = IW'(i);
        end
    end

    assign sel_x      = req_x[int'(idx)*XW +: XW];
    assign sel_y      = req_y[int'(idx)*YW +: YW];
    assign sel_colour = req_colour[int'(idx)*3 +: 3];

    always_comb begin
        ack_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack_onehot[i] = (int'(idx) == i);
        end
    end

    // The output registers always hold the pixel at (xc, yc), so each edge loads the
    // following pixel; LOAD seeds pixel (0,0) straight from the selected requester.
    always_comb begin
        last_col = (xc == XW'(XDIM - 1));
        last_row = (yc == YW'(YDIM - 1));
        xc_nxt   = last_col ? '0 : xc + 1'b1;
        yc_nxt   = last_col ? yc + 1'b1 : yc;
        if (state == S_LOAD) begin
            base_x = sel_x;
            base_y = sel_y;
            ox     = '0;
            oy     = '0;
        end else begin
            base_x = bx;
            base_y = by;
            ox     = xc_nxt;
            oy     = yc_nxt;
        end
        sum_x  = {1'b0, base_x} + {1'b0, ox};
        sum_y  = {1'b0, base_y} + {1'b0, oy};
        pix_ok = !sum_x[XW] && !sum_y[YW] &&
                 (sum_x < (XW+1)'(XSCREEN)) && (sum_y < (YW+1)'(YSCREEN));
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state      <= S_IDLE;
            idx        <= '0;
            bx         <= '0;
            by         <= '0;
            col        <= '0;
            xc         <= '0;
            yc         <= '0;
            ack        <= '0;
            busy       <= 1'b0;
            plot       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ack  <= '0;
                    plot <= 1'b0;
                    if (|req) begin
                        idx   <= winner;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bx         <= sel_x;
                    by         <= sel_y;
                    col        <= sel_colour;
                    xc         <= '0;
                    yc         <= '0;
                    plot       <= pix_ok;
                    vga_x      <= sum_x[XW-1:0];
                    vga_y      <= sum_y[YW-1:0];
                    vga_colour <= sel_colour;
                    state      <= S_DRAW;
                end
                S_DRAW: begin
                    if (last_col && last_row) begin
                        plot  <= 1'b0;
                        ack   <= ack_onehot;
                        state <= S_DONE;
                    end else begin
                        // Clipped pixels still consume their cycle so block time is fixed.
                        xc         <= xc_nxt;
                        yc         <= yc_nxt;
                        plot       <= pix_ok;
                        vga_x      <= sum_x[XW-1:0];
                        vga_y      <= sum_y[YW-1:0];
                        vga_colour <= col;
                    end
                end
                S_DONE: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snake_plot_scheduler.sv
// Directed and randomized check of snake_plot_scheduler against a per-block timing/raster model.
module tb_snake_plot_scheduler;
    localparam int NREQ    = 3;
    localparam int XW      = 8;
    localparam int YW      = 7;
    localparam int XDIM    = 10;
    localparam int YDIM    = 10;
    localparam int XSCREEN = 160;
    localparam int YSCREEN = 120;
    localparam int NPIX    = XDIM * YDIM;

    logic                CLOCK_50 = 1'b0;
    logic                Resetn;
    logic [NREQ-1:0]     req;
    logic [NREQ*XW-1:0]  req_x;
    logic [NREQ*YW-1:0]  req_y;
    logic [NREQ*3-1:0]   req_colour;
    logic [NREQ-1:0]     ack;
    logic                busy;
    logic                plot;
    logic [XW-1:0]       vga_x;
    logic [YW-1:0]       vga_y;
    logic [2:0]          vga_colour;

    snake_plot_scheduler dut (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .ack        (ack),
        .busy       (busy),
        .plot       (plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct { int cyc; int x; int y; int col; } pix_t;
    typedef struct { int cyc; int val; } ack_t;

    pix_t exp_pix[$];
    pix_t obs_pix[$];
    ack_t exp_ack[$];
    ack_t obs_ack[$];

    int n_cmp = 0;
    int n_err = 0;
    int rel = 0;
    int busy_cnt = 0;
    int exp_busy = 0;
    int last_ack = 0;

    bit active [NREQ];
    int arr    [NREQ];
    int rx     [NREQ];
    int ry     [NREQ];
    int rc     [NREQ];
    int drop_at[NREQ];
    int chg_at [NREQ];
    int chg_x  [NREQ];

    task automatic chk(input string tag, input int observed, input int expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < NREQ; i++) begin
            active[i]  = 1'b0;
            arr[i]     = 0;
            drop_at[i] = -1;
            chg_at[i]  = -1;
            chg_x[i]   = 0;
        end
    endtask

    task automatic set_req(input int i, input int x, input int y, input int c, input int a);
        active[i] = 1'b1;
        rx[i]     = x;
        ry[i]     = y;
        rc[i]     = c;
        arr[i]    = a;
    endtask

    // One clock: sample outputs in the middle of cycle rel, then apply requester behaviour.
    task automatic step();
        @(negedge CLOCK_50);
        rel++;
        if (plot === 1'b1) obs_pix.push_back('{rel, int'(vga_x), int'(vga_y), int'(vga_colour)});
        if (|ack) begin
            obs_ack.push_back('{rel, int'(ack)});
            req = req & ~ack;
        end
        if (busy === 1'b1) busy_cnt++;
        for (int i = 0; i < NREQ; i++) begin
            if (active[i] && arr[i] == rel) req[i] = 1'b1;
            if (drop_at[i] == rel) req[i] = 1'b0;
            if (chg_at[i] == rel) req_x[i*XW +: XW] = XW'(chg_x[i]);
        end
    endtask

    // Each block: granted at the first free cycle with a pending request (lowest index),
    // pixels in raster order starting two cycles later, ack after the last pixel,
    // next arbitration one cycle after the ack.
    task automatic model();
        int free_at;
        int nact;
        bit served[NREQ];
        free_at = 0;
        nact = 0;
        exp_pix.delete();
        exp_ack.delete();
        exp_busy = 0;
        last_ack = 0;
        for (int i = 0; i < NREQ; i++) begin
            served[i] = 1'b0;
            if (active[i]) nact++;
        end
        for (int k = 0; k < nact; k++) begin
            int g;
            int w;
            g = -1;
            w = -1;
            for (int c = free_at; c < free_at + 5000 && w < 0; c++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (w < 0 && active[i] && !served[i] && arr[i] <= c) begin
                        w = i;
                        g = c;
                    end
                end
            end
            if (w < 0) break;
            served[w] = 1'b1;
            for (int r = 0; r < YDIM; r++) begin
                for (int c = 0; c < XDIM; c++) begin
                    int px;
                    int py;
                    px = rx[w] + c;
                    py = ry[w] + r;
                    if (px < XSCREEN && py < YSCREEN && px < (1 << XW) && py < (1 << YW))
                        exp_pix.push_back('{g + 2 + r*XDIM + c, px, py, rc[w]});
                end
            end
            exp_ack.push_back('{g + 2 + NPIX, 1 << w});
            exp_busy += NPIX + 2;
            last_ack = g + 2 + NPIX;
            free_at  = g + 3 + NPIX;
        end
    endtask

    task automatic run(input string name);
        model();
        obs_pix.delete();
        obs_ack.delete();
        busy_cnt = 0;
        rel = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (active[i]) begin
                req_x[i*XW +: XW]     = XW'(rx[i]);
                req_y[i*YW +: YW]     = YW'(ry[i]);
                req_colour[i*3 +: 3]  = 3'(rc[i]);
                if (arr[i] == 0) req[i] = 1'b1;
            end
        end
        while (obs_ack.size() < exp_ack.size() && rel < last_ack + 50) step();
        repeat (3) step();
        chk({name, "_ack_count"}, obs_ack.size(), exp_ack.size());
        chk({name, "_plot_count"}, obs_pix.size(), exp_pix.size());
        chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
        for (int k = 0; k < exp_ack.size() && k < obs_ack.size(); k++) begin
            chk($sformatf("%s_ack%0d_cycle", name, k), obs_ack[k].cyc, exp_ack[k].cyc);
            chk($sformatf("%s_ack%0d_value", name, k), obs_ack[k].val, exp_ack[k].val);
        end
        for (int k = 0; k < exp_pix.size() && k < obs_pix.size(); k++) begin
            chk($sformatf("%s_pix%0d_cycle", name, k), obs_pix[k].cyc, exp_pix[k].cyc);
            chk($sformatf("%s_pix%0d_x", name, k), obs_pix[k].x, exp_pix[k].x);
            chk($sformatf("%s_pix%0d_y", name, k), obs_pix[k].y, exp_pix[k].y);
            chk($sformatf("%s_pix%0d_colour", name, k), obs_pix[k].col, exp_pix[k].col);
        end
        req = '0;
    endtask

    initial begin
        Resetn     = 1'b0;
        req        = '0;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;
        clear_cfg();

        // Reset state
        repeat (3) @(negedge CLOCK_50);
        chk("reset_plot", int'(plot), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ack", int'(ack), 0);
        chk("reset_vga_x", int'(vga_x), 0);
        chk("reset_vga_y", int'(vga_y), 0);
        chk("reset_vga_colour", int'(vga_colour), 0);
        Resetn = 1'b1;
        repeat (2) step();

        // Reset in the middle of a block
        obs_pix.delete();
        obs_ack.delete();
        busy_cnt = 0;
        rel = 0;
        req_x[XW +: XW]    = 8'd80;
        req_y[YW +: YW]    = 7'd60;
        req_colour[3 +: 3] = 3'b010;
        req[1] = 1'b1;
        while (rel < 50) step();
        Resetn = 1'b0;
        #1;
        chk("midrst_plot", int'(plot), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ack", int'(ack), 0);
        chk("midrst_plots_before", obs_pix.size(), 50 - 2 + 1);
        chk("midrst_acks_before", obs_ack.size(), 0);
        req = '0;
        repeat (2) step();
        Resetn = 1'b1;
        obs_pix.delete();
        obs_ack.delete();
        busy_cnt = 0;
        repeat (150) step();
        chk("postrst_acks", obs_ack.size(), 0);
        chk("postrst_plots", obs_pix.size(), 0);
        chk("postrst_busy", busy_cnt, 0);

        // Single request
        clear_cfg();
        set_req(1, 80, 60, 2, 0);
        run("single");

        // Simultaneous requests
        clear_cfg();
        set_req(0, 10, 20, 1, 0);
        set_req(1, 30, 40, 5, 0);
        set_req(2, 50, 70, 7, 0);
        run("simul");
        if (obs_ack.size() >= 2)
            chk("simul_ack_spacing", obs_ack[1].cyc - obs_ack[0].cyc, 3 + NPIX);

        // Higher priority arriving mid-block
        clear_cfg();
        set_req(2, 100, 5, 3, 0);
        set_req(0, 0, 0, 6, 20);
        run("late_hi");

        // Clipping at the screen corner
        clear_cfg();
        set_req(0, 155, 115, 4, 0);
        run("clip");
        chk("clip_plot_total", obs_pix.size(), 25);

        // Coordinate change and req drop after LOAD
        clear_cfg();
        set_req(1, 80, 60, 2, 0);
        chg_at[1]  = 5;
        chg_x[1]   = 20;
        drop_at[1] = 30;
        run("late_change");

        // Randomized requests, arrivals and coordinates (including off-screen and overflow)
        for (int t = 0; t < 6; t++) begin
            clear_cfg();
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                            int'($urandom_range(0, 7)), int'($urandom_range(0, 150)));
            end
            if (!active[0] && !active[1] && !active[2])
                set_req(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                        int'($urandom_range(0, 7)), 0);
            run($sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
